stack_ctrl: RTL

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_ctrl_pkg.sv | 14 +
 rtl/stack_ctrl_mem.sv | 25 ++
 rtl/stack_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared sizing constants and FSM state type for the stack controller.
package stack_ctrl_pkg;

  localparam int unsigned STACK_DEPTH = 64;
  localparam int unsigned STACK_AW    = 6;
  localparam int unsigned STACK_DW    = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DUMP_RD  = 2'd1,
    DUMP_FIN = 2'd2
  } state_t;

endpackage

// File: rtl/stack_ctrl_mem.sv
// Stack storage: one write port and one synchronous read port (1-cycle latency).
// Read is read-before-write, so a same-cycle write to the read address
// returns the old contents.
module stack_mem #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Write port and registered read port; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/stack_ctrl.sv
// Stack pointer, sticky error flags, pop read mux and contents-dump FSM.
module stack_ctrl
  import stack_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic [31:0] pop_data,
  output logic [6:0]  count,
  output logic        full,
  output logic        empty,
  output logic        ovf,
  output logic        unf,
  output logic        busy_err,
  input  logic        clr_err,
  input  logic        dump_start,
  output logic        dump_busy,
  output logic        dump_valid,
  output logic        dump_done,
  output logic [5:0]  dump_addr,
  output logic [31:0] dump_data
);

  state_t                state;
  logic [STACK_AW-1:0]   top_idx;
  logic [STACK_AW-1:0]   rd_idx;
  logic [STACK_AW-1:0]   pend_addr;
  logic                  rd_pend;
  logic                  rd_issue;
  logic                  acc_ok;
  logic                  do_push, do_pop, do_swap, do_pass;
  logic                  ovf_set, unf_set, berr_set;
  logic                  mem_we, mem_re;
  logic [STACK_AW-1:0]   mem_waddr, mem_raddr;
  logic [STACK_DW-1:0]   mem_rdata;
  logic [31:0]           pop_hold;
  logic                  pop_mem;

  assign full    = (count == 7'd64);
  assign empty   = (count == 7'd0);
  assign top_idx = count[STACK_AW-1:0] - STACK_AW'(1);

  assign acc_ok   = (state == IDLE) && !rst;
  assign do_push  = acc_ok &&  push && !pop && !full;
  assign do_pop   = acc_ok && !push &&  pop && !empty;
  assign do_swap  = acc_ok &&  push &&  pop && !empty;
  assign do_pass  = acc_ok &&  push &&  pop &&  empty;
  assign ovf_set  = acc_ok &&  push && !pop &&  full;
  assign unf_set  = acc_ok && !push &&  pop &&  empty;
  assign berr_set = !rst && (state != IDLE) && (push || pop);
  assign rd_issue = !rst && (state == DUMP_RD);

  assign mem_we    = do_push || do_swap;
  assign mem_waddr = do_swap ? top_idx : count[STACK_AW-1:0];
  assign mem_re    = do_pop || do_swap || rd_issue;
  assign mem_raddr = rd_issue ? rd_idx : top_idx;

  // The memory output is only valid the cycle after a read; pop_hold keeps
  // the popped word afterwards so dump reads cannot disturb pop_data.
  assign pop_data = pop_mem ? mem_rdata : pop_hold;

  stack_mem #(
    .DW (STACK_DW),
    .AW (STACK_AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (push_data),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Stack pointer.
  always_ff @(posedge clk) begin
    if (rst)          count <= '0;
    else if (do_push) count <= count + 7'd1;
    else if (do_pop)  count <= count - 7'd1;
  end

  // Popped-word capture: memory-sourced pops select the RAM output for one
  // cycle, non-memory results (empty pop, pass-through) load the hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_hold <= '0;
      pop_mem  <= 1'b0;
    end else begin
      if (pop_mem) pop_hold <= mem_rdata;
      pop_mem <= do_pop || do_swap;
      if (do_pass)      pop_hold <= push_data;
      else if (unf_set) pop_hold <= '0;
    end
  end

  // Sticky error flags; a coincident set beats clr_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf      <= 1'b0;
      unf      <= 1'b0;
      busy_err <= 1'b0;
    end else begin
      ovf      <= ovf_set  || (ovf      && !clr_err);
      unf      <= unf_set  || (unf      && !clr_err);
      busy_err <= berr_set || (busy_err && !clr_err);
    end
  end

  // Dump FSM: descending reads, data returned one cycle after each read,
  // DUMP_FIN waits for the last read to drain before pulsing dump_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dump_busy  <= 1'b0;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
      rd_idx     <= '0;
      rd_pend    <= 1'b0;
      pend_addr  <= '0;
    end else begin
      dump_valid <= rd_pend;
      if (rd_pend) begin
        dump_addr <= pend_addr;
        dump_data <= mem_rdata;
      end
      rd_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (dump_start) begin
            dump_busy <= 1'b1;
            if (empty) begin
              state <= DUMP_FIN;
            end else begin
              state  <= DUMP_RD;
              rd_idx <= top_idx;
            end
          end
        end
        DUMP_RD: begin
          rd_pend   <= 1'b1;
          pend_addr <= rd_idx;
          if (rd_idx == '0) state <= DUMP_FIN;
          else              rd_idx <= rd_idx - STACK_AW'(1);
        end
        DUMP_FIN: begin
          if (!rd_pend) begin
            if (!dump_done) begin
              dump_done <= 1'b1;
            end else begin
              dump_done <= 1'b0;
              dump_busy <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          dump_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
